mbus_timer: RTL
===============

Name: mbus_timer

Overview:
- Memory-mapped down-counting timer peripheral on the CPU memory bus (mbus), downstream of the cpu2 core.
- Decodes the CPU address, accepts register writes on the write strobe and drives read data back for the core to latch.
- Provides a programmable prescaler, reload/one-shot modes, an overflow status flag and a level interrupt request.
- Instanced next to program memory; the top level ORs its dout into mbus_din, which is valid because dout is zero when the block is not selected.

Parameters:
- WIDTH, 32, data width of the bus and of the counter/reload registers.
- ADDR_SIZE, 32, bus address width.
- BASE, 32'hFF10, word address of the register block; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  ADDR_SIZE  bus address (cpu mbus_aout).
- din  in  WIDTH  write data (cpu mbus_dout).
- wen  in  1  write strobe (cpu mbus_wen); high for one clock per store.
- dout  out  WIDTH  read data; combinational from addr and registers; 0 when not selected.
- cs  out  1  high when addr[ADDR_SIZE-1:2]==BASE[ADDR_SIZE-1:2].
- irq  out  1  interrupt request, equal to ovf & ien.

Behaviour:
- Register map, word offset addr[1:0]:
  - 0 CNT: counter. Read/write; a write loads the counter.
  - 1 RLD: reload value. Read/write.
  - 2 CTRL: bit0 run, bit1 arl (auto-reload), bit2 ien, bits[15:8] psc. Other bits read 0 and writes to them are ignored.
  - 3 STAT: bit0 ovf. Reads return {WIDTH-1 zeros, ovf}. Writing 1 to bit0 clears ovf; writing 0 has no effect.
- Reset (async): CNT, RLD, CTRL, ovf and the internal prescaler count pc are all 0. dout=0, cs depends only on addr, irq=0.
- Write: occurs at the clock edge when wen & cs. A write with wen low or cs low has no effect.
- Prescaler:
  - While run=1: if pc==psc, a tick is generated and pc<=0; otherwise pc<=pc+1.
  - psc=0 gives one tick every clock; psc=N gives one tick every N+1 clocks.
  - While run=0, pc holds and no ticks are generated.
  - Any write to CTRL clears pc to 0. That cycle produces no tick.
- Tick with CNT!=0: CNT<=CNT-1.
- Tick with CNT==0:
  - ovf<=1.
  - If arl=1, CNT<=RLD and run stays 1.
  - If arl=0, CNT stays 0 and run<=0 (one-shot stop).
- Period: with arl=1, RLD=R and psc=P, ovf is set every (R+1)*(P+1) clocks.
- Simultaneous events:
  - CPU write to CNT in a tick cycle: the write wins and the tick is lost.
  - CPU write to CTRL in an underflow cycle: the written value wins, including run.
  - STAT clear and an underflow in the same cycle: set wins, so ovf=1.
- Arithmetic: CNT wraps only via reload; it never decrements below 0. WIDTH-bit unsigned.
- irq is combinational from registered ovf and ien; it stays high until ovf is cleared or ien is written to 0.
- Reset asserted mid-count: all state clears immediately, independent of clk.

Test Plan:
1. Reset, then read offsets 0..3 at BASE -> dout=0 each. Read at BASE+4 -> cs=0, dout=0.
2. Write RLD=3, CNT=3, CTRL=0x0003 (run, arl, psc=0) -> CNT reads 2,1,0,3,2 on successive clocks; ovf sets 4 clocks after the CTRL write and every 4 clocks thereafter.
3. CNT=2, CTRL=0x0201 (psc=2, one-shot) -> CNT decrements every 3 clocks; ovf=1 and run=0 on the 9th clock; CTRL reads 0x0200; CNT stays 0.
4. CTRL=0x0005 with ovf set -> irq=1. Write STAT=1 -> irq=0 next cycle. Write STAT=0 with ovf=1 -> ovf stays 1.
5. Align a STAT clear with an underflow cycle -> ovf=1. Align a CNT=0x10 write with a tick -> CNT reads 0x10 next cycle.
6. Assert reset asynchronously mid-count (between clock edges) -> CNT, CTRL, STAT and irq are 0 before the next clk edge; counting stays stopped after release.

Source files
------------

// File: rtl/mbus_timer.sv
// mbus_timer: memory-mapped down-counting timer on the cpu2 memory bus.
// Bus protocol: a store is a single-cycle strobe. wen is high for exactly one
// clock, and the write commits at that rising edge when cs is also high. Reads
// have no handshake. dout follows addr combinationally and is zero when the
// block is not selected, so the top level can OR it into mbus_din.
// Register map (word offset addr[1:0]):
//   0 CNT  counter, read/write
//   1 RLD  reload value, read/write
//   2 CTRL bit0 run, bit1 arl, bit2 ien, bits[15:8] psc
//   3 STAT bit0 ovf, write 1 to clear
module mbus_timer #(
    parameter int                   WIDTH     = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] BASE      = 'hFF10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wen,
    output logic [WIDTH-1:0]     dout,
    output logic                 cs,
    output logic                 irq
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             run_q, run_d;
    logic             arl_q, arl_d;
    logic             ien_q, ien_d;
    logic [7:0]       psc_q, psc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       pc_q, pc_d;

    logic [1:0] off;
    logic       wr_cnt, wr_rld, wr_ctrl, wr_stat;
    logic       tick;
    logic       underflow;

    // CTRL and STAT only use a few data bits; the rest are deliberately ignored.
    logic unused_din;
    assign unused_din = ^{din[WIDTH-1:16], din[7:3]};

    assign cs  = (addr[ADDR_SIZE-1:2] == BASE[ADDR_SIZE-1:2]);
    assign off = addr[1:0];
    assign irq = ovf_q & ien_q;

    assign wr_cnt  = wen & cs & (off == 2'd0);
    assign wr_rld  = wen & cs & (off == 2'd1);
    assign wr_ctrl = wen & cs & (off == 2'd2);
    assign wr_stat = wen & cs & (off == 2'd3);

    // A CTRL write restarts the prescaler, so that cycle never ticks.
    assign tick      = run_q & ~wr_ctrl & (pc_q == psc_q);
    // A CNT write in the same cycle swallows the tick, including its underflow.
    assign underflow = tick & ~wr_cnt & (cnt_q == '0);

    // Read mux: combinational from addr, zero when the block is not addressed.
    always_comb begin
        dout = '0;
        if (cs) begin
            case (off)
                2'd0: dout = cnt_q;
                2'd1: dout = rld_q;
                2'd2: begin
                    dout[15:8] = psc_q;
                    dout[2:0]  = {ien_q, arl_q, run_q};
                end
                default: dout[0] = ovf_q;
            endcase
        end
    end

    // Next-state logic. A CPU write takes priority over the timer's own update.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        rld_d = rld_q;
        run_d = run_q;
        arl_d = arl_q;
        ien_d = ien_q;
        psc_d = psc_q;
        ovf_d = ovf_q;

        if (wr_ctrl) begin
            pc_d = 8'd0;
        end else if (run_q) begin
            pc_d = (pc_q == psc_q) ? 8'd0 : pc_q + 8'd1;
        end

        if (wr_cnt) begin
            cnt_d = din;
        end else if (tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (arl_q) begin
                cnt_d = rld_q;
            end
        end

        if (wr_rld) begin
            rld_d = din;
        end

        if (wr_ctrl) begin
            run_d = din[0];
            arl_d = din[1];
            ien_d = din[2];
            psc_d = din[15:8];
        end else if (underflow && !arl_q) begin
            run_d = 1'b0;
        end

        // Setting on underflow beats a simultaneous clear.
        if (underflow) begin
            ovf_d = 1'b1;
        end else if (wr_stat && din[0]) begin
            ovf_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            rld_q <= '0;
            run_q <= 1'b0;
            arl_q <= 1'b0;
            ien_q <= 1'b0;
            psc_q <= 8'd0;
            ovf_q <= 1'b0;
            pc_q  <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
            run_q <= run_d;
            arl_q <= arl_d;
            ien_q <= ien_d;
            psc_q <= psc_d;
            ovf_q <= ovf_d;
            pc_q  <= pc_d;
        end
    end

endmodule
